// File: rtl/hamming_decode_arbiter.sv
// hamming_decode_arbiter
//   Shared Hamming(21,16) single-error-correcting decoder with a round-robin
//   front end for two requesters. An accepted codeword is decoded in one
//   cycle. The corrected payload, requester tag and status are then held
//   behind a valid/ready output until the consumer takes them. Saturating
//   counters record corrected and uncorrectable events.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req0_valid/req0_cw/...   requester 0 offer (codeword bit i = position i+1)
//   req1_valid/req1_cw/...   requester 1 offer
//   req0_ready, req1_ready   accept strobes (valid & ready on rising edge)
//   out_valid, out_ready     result handshake
//   out_data                 corrected 16-bit payload
//   out_tag                  requester that produced the result
//   out_syndrome             raw 5-bit syndrome
//   out_corrected            single-bit error was fixed
//   out_uncorrectable        syndrome in 22..31
//   corr_cnt, uncorr_cnt     saturating event counters
//   cnt_clr                  synchronous clear of both counters
module hamming_decode_arbiter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [0:20]      req0_cw,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [0:20]      req1_cw,
    output logic             req1_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_tag,
    output logic [4:0]       out_syndrome,
    output logic             out_corrected,
    output logic             out_uncorrectable,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt,
    input  logic             cnt_clr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        OUT    = 2'd2
    } state_t;

    // Parity-check masks: bit i is set when bit k of position (i+1) is set.
    localparam logic [0:20] MASK0 = 21'b101010101010101010101;
    localparam logic [0:20] MASK1 = 21'b011001100110011001100;
    localparam logic [0:20] MASK2 = 21'b000111100001111000011;
    localparam logic [0:20] MASK3 = 21'b000000011111111000000;
    localparam logic [0:20] MASK4 = 21'b000000000000000111111;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t      state;
    state_t      state_next;
    logic        last;
    logic [0:20] cw_reg;
    logic        tag_reg;

    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        accept_tag;
    logic [0:20] accept_cw;

    logic [4:0]  syndrome;
    logic [0:20] cw_fixed;
    logic [15:0] payload;
    logic        corr_flag;
    logic        uncorr_flag;

    // Arbitration and next-state logic. Ready is gated by rst so both
    // readies read 0 for the whole reset interval.
    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        accept_tag = 1'b0;
        accept_cw  = req0_cw;
        grant0     = req0_valid && (!req1_valid || last);
        grant1     = req1_valid && (!req0_valid || !last);
        case (state)
            IDLE: begin
                req0_ready = grant0 && !rst;
                req1_ready = grant1 && !rst;
                if (grant0 || grant1) begin
                    accept     = 1'b1;
                    accept_tag = grant1;
                    accept_cw  = grant1 ? req1_cw : req0_cw;
                    state_next = DECODE;
                end
            end
            DECODE: state_next = OUT;
            OUT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Syndrome, single-bit correction and payload extraction.
    always_comb begin
        syndrome[0] = ^(cw_reg & MASK0);
        syndrome[1] = ^(cw_reg & MASK1);
        syndrome[2] = ^(cw_reg & MASK2);
        syndrome[3] = ^(cw_reg & MASK3);
        syndrome[4] = ^(cw_reg & MASK4);
        corr_flag   = (syndrome != 5'd0) && (syndrome <= 5'd21);
        uncorr_flag = (syndrome >= 5'd22);
        cw_fixed    = cw_reg;
        if (corr_flag) begin
            cw_fixed[syndrome - 5'd1] = ~cw_reg[syndrome - 5'd1];
        end
        payload = {cw_fixed[2], cw_fixed[4], cw_fixed[5], cw_fixed[6],
                   cw_fixed[8:14], cw_fixed[16:20]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            last              <= 1'b1;
            cw_reg            <= '0;
            tag_reg           <= 1'b0;
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_tag           <= 1'b0;
            out_syndrome      <= '0;
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cw_reg  <= accept_cw;
                tag_reg <= accept_tag;
                last    <= accept_tag;
            end
            if (state == DECODE) begin
                out_valid         <= 1'b1;
                out_data          <= payload;
                out_tag           <= tag_reg;
                out_syndrome      <= syndrome;
                out_corrected     <= corr_flag;
                out_uncorrectable <= uncorr_flag;
            end else if (state == OUT && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Counters: clear wins over a same-edge increment; saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (state == DECODE) begin
            if (corr_flag && corr_cnt != '1) begin
                corr_cnt <= corr_cnt + CNT_ONE;
            end
            if (uncorr_flag && uncorr_cnt != '1) begin
                uncorr_cnt <= uncorr_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hamming_decode_arbiter.sv
// Directed testbench for hamming_decode_arbiter. A second instance with
// CNT_W=2 shares every input and is used for counter saturation.
module tb_hamming_decode_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid = 1'b0;
    logic [0:20] req0_cw = '0;
    logic        req1_valid = 1'b0;
    logic [0:20] req1_cw = '0;
    logic        out_ready = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        req0_ready, req1_ready, out_valid, out_tag;
    logic        out_corrected, out_uncorrectable;
    logic [15:0] out_data;
    logic [4:0]  out_syndrome;
    logic [15:0] corr_cnt, uncorr_cnt;

    logic        s_req0_ready, s_req1_ready, s_out_valid, s_out_tag;
    logic        s_out_corrected, s_out_uncorrectable;
    logic [15:0] s_out_data;
    logic [4:0]  s_out_syndrome;
    logic [1:0]  s_corr_cnt, s_uncorr_cnt;

    int checks = 0;
    int errors = 0;
    logic [0:20] w;

    always #5 clk = ~clk;

    hamming_decode_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_cw(req0_cw), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_cw(req1_cw), .req1_ready(req1_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_syndrome(out_syndrome),
        .out_corrected(out_corrected), .out_uncorrectable(out_uncorrectable),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .cnt_clr(cnt_clr)
    );

    hamming_decode_arbiter #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_cw(req0_cw), .req0_ready(s_req0_ready),
        .req1_valid(req1_valid), .req1_cw(req1_cw), .req1_ready(s_req1_ready),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_tag(s_out_tag), .out_syndrome(s_out_syndrome),
        .out_corrected(s_out_corrected), .out_uncorrectable(s_out_uncorrectable),
        .corr_cnt(s_corr_cnt), .uncorr_cnt(s_uncorr_cnt), .cnt_clr(cnt_clr)
    );

    // Offer one codeword from a single requester while the DUT is idle and
    // return one time step after the edge that loads the result registers.
    task automatic offer(input logic tag, input logic [0:20] cw, input logic clr);
        @(negedge clk);
        if (tag) begin
            req1_valid = 1'b1;
            req1_cw    = cw;
        end else begin
            req0_valid = 1'b1;
            req0_cw    = cw;
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        cnt_clr    = clr;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        req0_valid = 1'b1;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", out_valid); end
        checks++; if (out_data !== 16'h0000 || out_syndrome !== 5'd0 || out_tag !== 1'b0) begin errors++; $display("FAIL rst_fields: data %h syn %0d tag %0b want 0", out_data, out_syndrome, out_tag); end
        checks++; if (out_corrected !== 1'b0 || out_uncorrectable !== 1'b0) begin errors++; $display("FAIL rst_flags: got %0b%0b want 00", out_corrected, out_uncorrectable); end
        checks++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d %0d want 0 0", corr_cnt, uncorr_cnt); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b%0b want 00", req0_ready, req1_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rel_ready: got %0b%0b want 10", req0_ready, req1_ready); end
        req0_valid = 1'b0;
    endtask

    task automatic test_clean();
        @(negedge clk);
        req0_valid = 1'b1;
        req0_cw    = '0;
        out_ready  = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL clean_ready: got %0b%0b want 10", req0_ready, req1_ready); end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || req0_ready !== 1'b0) begin errors++; $display("FAIL clean_decode: valid %0b ready %0b want 0 0", out_valid, req0_ready); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clean_latency: got %0b want 1", out_valid); end
        checks++; if (out_data !== 16'h0000 || out_syndrome !== 5'd0 || out_tag !== 1'b0) begin errors++; $display("FAIL clean_fields: data %h syn %0d tag %0b want 0000 0 0", out_data, out_syndrome, out_tag); end
        checks++; if (out_corrected !== 1'b0 || out_uncorrectable !== 1'b0) begin errors++; $display("FAIL clean_flags: got %0b%0b want 00", out_corrected, out_uncorrectable); end
        checks++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0) begin errors++; $display("FAIL clean_cnt: got %0d %0d want 0 0", corr_cnt, uncorr_cnt); end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clean_handshake: got %0b want 0", out_valid); end
    endtask

    task automatic test_single();
        w = '0;
        w[4] = 1'b1;
        offer(1'b1, w, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_tag !== 1'b1) begin errors++; $display("FAIL single_vt: valid %0b tag %0b want 1 1", out_valid, out_tag); end
        checks++; if (out_syndrome !== 5'd5) begin errors++; $display("FAIL single_syn: got %0d want 5", out_syndrome); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL single_data: got %h want 0000", out_data); end
        checks++; if (out_corrected !== 1'b1 || out_uncorrectable !== 1'b0) begin errors++; $display("FAIL single_flags: got %0b%0b want 10", out_corrected, out_uncorrectable); end
        checks++; if (corr_cnt !== 16'd1 || uncorr_cnt !== 16'd0) begin errors++; $display("FAIL single_cnt: got %0d %0d want 1 0", corr_cnt, uncorr_cnt); end
        drain();
    endtask

    task automatic test_parity();
        w = '1;
        offer(1'b0, w, 1'b0);
        checks++; if (out_syndrome !== 5'd1) begin errors++; $display("FAIL parity_syn: got %0d want 1", out_syndrome); end
        checks++; if (out_data !== 16'hFFFF || out_tag !== 1'b0) begin errors++; $display("FAIL parity_data: data %h tag %0b want ffff 0", out_data, out_tag); end
        checks++; if (out_corrected !== 1'b1 || out_uncorrectable !== 1'b0) begin errors++; $display("FAIL parity_flags: got %0b%0b want 10", out_corrected, out_uncorrectable); end
        checks++; if (corr_cnt !== 16'd2) begin errors++; $display("FAIL parity_cnt: got %0d want 2", corr_cnt); end
        drain();
    endtask

    task automatic test_double();
        w = '0;
        w[2]  = 1'b1;
        w[20] = 1'b1;
        offer(1'b0, w, 1'b0);
        checks++; if (out_syndrome !== 5'd22) begin errors++; $display("FAIL double_syn: got %0d want 22", out_syndrome); end
        checks++; if (out_data !== 16'h8001) begin errors++; $display("FAIL double_data: got %h want 8001", out_data); end
        checks++; if (out_corrected !== 1'b0 || out_uncorrectable !== 1'b1) begin errors++; $display("FAIL double_flags: got %0b%0b want 01", out_corrected, out_uncorrectable); end
        checks++; if (uncorr_cnt !== 16'd1 || corr_cnt !== 16'd2) begin errors++; $display("FAIL double_cnt: got %0d %0d want 2 1", corr_cnt, uncorr_cnt); end
        drain();
    endtask

    task automatic test_midreset();
        w = '0;
        w[4] = 1'b1;
        offer(1'b0, w, 1'b0);
        checks++; if (out_valid !== 1'b1 || corr_cnt !== 16'd3) begin errors++; $display("FAIL mid_pre: valid %0b cnt %0d want 1 3", out_valid, corr_cnt); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_corrected !== 1'b0) begin errors++; $display("FAIL mid_drop: valid %0b corr %0b want 0 0", out_valid, out_corrected); end
        checks++; if (corr_cnt !== 16'd0 || uncorr_cnt !== 16'd0 || s_corr_cnt !== 2'd0) begin errors++; $display("FAIL mid_cnt: got %0d %0d %0d want 0 0 0", corr_cnt, uncorr_cnt, s_corr_cnt); end
        @(negedge clk);
        rst        = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL mid_grant: got %0b%0b want 10", req0_ready, req1_ready); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_fairness();
        logic        e;
        logic [15:0] exp_data;
        @(negedge clk);
        req0_cw    = '0;
        req1_cw    = '1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        out_ready  = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            e = (g % 2) == 1;
            exp_data = e ? 16'hFFFF : 16'h0000;
            checks++; if (req0_ready !== !e || req1_ready !== e) begin errors++; $display("FAIL fair_grant%0d: got %0b%0b want %0b%0b", g, req0_ready, req1_ready, !e, e); end
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1 || out_tag !== e || out_data !== exp_data) begin errors++; $display("FAIL fair_out%0d: valid %0b tag %0b data %h want 1 %0b %h", g, out_valid, out_tag, out_data, e, exp_data); end
            for (int s = 0; s < 5; s++) begin
                @(posedge clk);
                #1;
                checks++; if (out_valid !== 1'b1 || out_tag !== e || out_data !== exp_data || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL fair_stall%0d: valid %0b tag %0b data %h rdy %0b%0b want 1 %0b %h 00", g, out_valid, out_tag, out_data, req0_ready, req1_ready, e, exp_data); end
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fair_hs%0d: got %0b want 0", g, out_valid); end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_sat;
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        checks++; if (corr_cnt !== 16'd0 || s_corr_cnt !== 2'd0) begin errors++; $display("FAIL sat_clr: got %0d %0d want 0 0", corr_cnt, s_corr_cnt); end
        for (int i = 1; i <= 4; i++) begin
            w = '0;
            w[i + 8] = 1'b1;
            offer(1'b0, w, 1'b0);
            exp_sat = (i > 3) ? 2'd3 : 2'(i);
            checks++; if (out_syndrome !== 5'(i + 9) || s_corr_cnt !== exp_sat || corr_cnt !== 16'(i)) begin errors++; $display("FAIL sat_word%0d: syn %0d cnt2 %0d cnt %0d want %0d %0d %0d", i, out_syndrome, s_corr_cnt, corr_cnt, i + 9, exp_sat, i); end
            drain();
        end
    endtask

    task automatic test_clr_priority();
        w = '0;
        w[7] = 1'b1;
        offer(1'b1, w, 1'b1);
        checks++; if (out_corrected !== 1'b1 || out_syndrome !== 5'd8) begin errors++; $display("FAIL clr_word: corr %0b syn %0d want 1 8", out_corrected, out_syndrome); end
        checks++; if (corr_cnt !== 16'd0 || s_corr_cnt !== 2'd0) begin errors++; $display("FAIL clr_prio: got %0d %0d want 0 0", corr_cnt, s_corr_cnt); end
        drain();
        offer(1'b0, w, 1'b0);
        checks++; if (corr_cnt !== 16'd1 || s_corr_cnt !== 2'd1) begin errors++; $display("FAIL clr_after: got %0d %0d want 1 1", corr_cnt, s_corr_cnt); end
        drain();
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_parity();
        test_double();
        test_midreset();
        test_fairness();
        test_saturation();
        test_clr_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_decode_arbiter.md
# hamming_decode_arbiter

Sequential front end for the team's Hamming(21,16) single-error-correcting decode datapath. The block shares one syndrome/correction engine between two requesters and grants them round-robin. It registers the corrected 16-bit payload with requester tag and status behind a valid/ready output, and keeps saturating error statistics. It sits between the link receivers and the payload consumer.

## Interface
- `CNT_W`, default 16: width of each error-statistics counter.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous and active-high; all state goes to reset values immediately.
- `req0_valid` / `req1_valid` input 1: requester 0/1 offers a codeword.
- `req0_cw` / `req1_cw` input [0:20]: codeword; bit i is Hamming position i+1. Parity lives at positions 1, 2, 4, 8 and 16.
- `req0_ready` / `req1_ready` output 1: the codeword is accepted on the edge where valid and ready are both high.
- `out_valid` output 1: the result registers hold a result.
- `out_ready` input 1: the consumer takes the result.
- `out_data` output [15:0]: corrected payload.
- `out_tag` output 1: the requester that produced this result.
- `out_syndrome` output [4:0]: raw syndrome.
- `out_corrected` output 1: a single-bit error was fixed.
- `out_uncorrectable` output 1: the syndrome was 22–31.
- `corr_cnt`, `uncorr_cnt` output [CNT_W-1:0]: saturating event counts.
- `cnt_clr` input 1: synchronous clear of both counters.

## Operation
- **FSM states:** IDLE, DECODE, OUT.
- **IDLE:**
  - `reqN_ready` follows the arbitration grant; all other outputs hold.
  - On a handshake, capture `cw_reg` and `tag_reg`, then go to DECODE.
- **Arbitration:**
  - A `last` register holds the last granted requester; its reset value is 1, so requester 0 wins first.
  - If both requesters are valid, grant `!last`; if only one is valid, grant it.
  - At most one ready is high at a time, and ready is high only in IDLE.
  - Ready may depend combinationally on valid. Valid must not depend on ready.
- **DECODE:** one cycle.
  - Syndrome bit k = XOR of `cw_reg[i]` over all i where bit k of (i+1) is 1.
  - S = 0: no change.
  - S = 1..21: invert `cw_reg[S-1]`; set `out_corrected`.
  - S = 22..31: no change; set `out_uncorrectable`.
  - Payload, MSB first: `out_data` = {cw[2], cw[4], cw[5], cw[6], cw[8..14], cw[16..20]}, taken from the corrected word.
  - Load all `out_*` registers, then go to OUT.
- **OUT:**
  - `out_valid` = 1 and all `out_*` held stable.
  - On `out_ready`, go to IDLE and clear `out_valid`.
- **Counters:**
  - Increment on the DECODE→OUT transition per status flag.
  - Saturate at all-ones with no wrap.
  - `cnt_clr` has priority over a same-cycle increment, so the counter reads 0.
- **Reset values:**
  - FSM = IDLE, `last` = 1.
  - `out_valid`, `out_data`, `out_tag`, `out_syndrome`, `out_corrected`, `out_uncorrectable` all 0.
  - Both counters 0; both readies 0 while `rst` is high.
- **Reset during DECODE or OUT:** the in-flight word is discarded, no counter increments, and `out_valid` drops immediately.

## Timing
- Accept on edge N; DECODE during cycle N+1; `out_valid` high after edge N+1.
- Latency is 2 edges.
- After the output handshake on edge M, the FSM is in IDLE during cycle M+1, and the next accept is possible on edge M+1.
- Peak throughput is one word per 3 cycles.
- `out_*` fields change only on the DECODE→OUT edge.
- Counters update on that same edge and are visible the cycle after.
- A requester that stays valid while the other is granted keeps its codeword stable. It wins the next arbitration.

## Test plan
- **Clean word:** `req0_cw` all zeros, `out_ready`=1 → `out_valid` 2 edges after accept; `out_data`=16'h0000, `out_syndrome`=0, `out_tag`=0, both flags 0; counters unchanged.
- **Single error:** `req1_cw` all zeros with position 5 set (`cw[4]`=1) → `out_syndrome`=5, `out_corrected`=1, `out_data`=16'h0000, `out_tag`=1; `corr_cnt`=1.
- **Parity-bit error:** `req0_cw` all ones (21 bits) → `out_syndrome`=1; `cw[0]` flipped; `out_data`=16'hFFFF, `out_corrected`=1.
- **Double error:** all zeros with positions 3 and 21 set → `out_syndrome`=22, `out_uncorrectable`=1; `out_data` has bits 15 and 0 set (16'h8001), uncorrected; `uncorr_cnt`=1.
- **Fairness/backpressure:** both requesters valid continuously, `out_ready` low for 5 cycles then high → grants alternate 0,1,0,1; `out_*` stable while stalled; no second accept until the handshake.
- **Reset/saturation:**
  - `rst` asserted during OUT → `out_valid`=0 at once; counters 0; first grant after release goes to requester 0.
  - With `CNT_W`=2, four single-error words → `corr_cnt`=3.
  - `cnt_clr` in the same cycle as an increment → 0.
